ipsxe_floating_point_fma_arbiter_v1_0: RTL and testbench

Round-robin scheduler that shares one pipelined single-precision FMA datapath among `NUM_REQ` requesters. Each requester offers an (a, b, c) operand triple over valid/ready. The block picks one triple per enabled cycle, drives the FMA, and tags the issue in a delay line matched to the FMA pipeline depth. Completed results, with invalid-op flag and requester ID, go to a single response stream through a credit-protected result FIFO. It sits between the FMA core and the functional units that issue multiply-add work.

---
 rtl/ipsxe_floating_point_fma_arbiter_v1_0_pkg.sv | 36 +++
 rtl/ipsxe_floating_point_register_v1_0.sv | 28 ++
 rtl/ipsxe_floating_point_sync_fifo_v1_0.sv | 57 +++++
 rtl/ipsxe_floating_point_fma_arbiter_v1_0.sv | 185 ++++++++++++++++++
 tb/tb_ipsxe_floating_point_fma_arbiter_v1_0.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ipsxe_floating_point_fma_arbiter_v1_0_pkg.sv
// ----------------------------------------------------------------------------
// ipsxe_floating_point_fma_arbiter_v1_0_pkg
// Shared sizing helpers for the FMA arbiter slice: a clog2 function, the
// requester ID width and the width of one packed result-FIFO entry.
// A FIFO entry is packed {result, invalid_op, id} with id in the LSBs.
// No ports (package).
// ----------------------------------------------------------------------------
package ipsxe_floating_point_fma_arbiter_v1_0_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Requester index width, never narrower than one bit.
    function automatic int id_width(input int num_req);
        return (clog2(num_req) < 1) ? 1 : clog2(num_req);
    endfunction

    function automatic int fma_word_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // {result, invalid_op, id}
    function automatic int fifo_entry_width(input int word_w, input int id_w);
        return word_w + 1 + id_w;
    endfunction

endpackage

// File: rtl/ipsxe_floating_point_register_v1_0.sv
// ----------------------------------------------------------------------------
// ipsxe_floating_point_register_v1_0
// Enabled pipeline register with asynchronous active-low reset to zero.
// Ports: clk_i, rst_n_i, en_i (load enable), d_i / q_o (DATA_WIDTH data).
// ----------------------------------------------------------------------------
module ipsxe_floating_point_register_v1_0 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ipsxe_floating_point_sync_fifo_v1_0.sv
// ----------------------------------------------------------------------------
// ipsxe_floating_point_sync_fifo_v1_0
// First-word-fall-through synchronous FIFO, asynchronous active-low reset.
// Ports: clk_i, rst_n_i, wr_en_i/wr_data_i (push), rd_en_i (pop, must only be
// asserted while not empty), rd_data_o (head entry, zero when empty),
// not_empty_o. Enables arrive already qualified by the caller's clock enable.
// ----------------------------------------------------------------------------
module ipsxe_floating_point_sync_fifo_v1_0
    import ipsxe_floating_point_fma_arbiter_v1_0_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  not_empty_o
);

    localparam int AW = clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]           wrPtr_q;
    logic [AW:0]           rdPtr_q;
    logic                  empty;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wrPtr_q == rdPtr_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (wr_en_i) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (rd_en_i) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wrPtr_q[AW-1:0]] <= wr_data_i;
        end
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign rd_data_o   = empty ? '0 : mem_q[rdPtr_q[AW-1:0]];
    assign not_empty_o = ~empty;

endmodule

// File: rtl/ipsxe_floating_point_fma_arbiter_v1_0.sv
// ----------------------------------------------------------------------------
// ipsxe_floating_point_fma_arbiter_v1_0
// Round-robin scheduler sharing one pipelined FMA among NUM_REQ requesters.
// Ports:
//   i_clk, i_rst_n (async active-low), i_aclken (freezes all state when low)
//   i_req_valid/o_req_ready, i_req_a/b/c : per-requester operand handshakes
//   o_fma_a/b/c, o_fma_valid             : operands and issue strobe to FMA
//   i_fma_result, i_fma_invalid_op       : FMA outputs, FMA_LATENCY later
//   o_rsp_valid/i_rsp_ready, o_rsp_result, o_rsp_invalid_op, o_rsp_id
//   o_busy                               : work in flight or queued
// ----------------------------------------------------------------------------
module ipsxe_floating_point_fma_arbiter_v1_0
    import ipsxe_floating_point_fma_arbiter_v1_0_pkg::*;
#(
    parameter int  EXP_WIDTH   = 8,
    parameter int  MAN_WIDTH   = 23,
    parameter int  NUM_REQ     = 4,
    parameter int  FMA_LATENCY = 8,
    parameter int  FIFO_DEPTH  = 16,
    localparam int WIDTH       = fma_word_width(EXP_WIDTH, MAN_WIDTH),
    localparam int ID_WIDTH    = id_width(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_aclken,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_c,
    output logic [WIDTH-1:0]         o_fma_a,
    output logic [WIDTH-1:0]         o_fma_b,
    output logic [WIDTH-1:0]         o_fma_c,
    output logic                     o_fma_valid,
    input  logic [WIDTH-1:0]         i_fma_result,
    input  logic                     i_fma_invalid_op,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [WIDTH-1:0]         o_rsp_result,
    output logic                     o_rsp_invalid_op,
    output logic [ID_WIDTH-1:0]      o_rsp_id,
    output logic                     o_busy
);

    localparam int CREDIT_WIDTH = clog2(FIFO_DEPTH + 1);
    localparam int TAG_WIDTH    = 1 + ID_WIDTH;
    localparam int ENTRY_WIDTH  = fifo_entry_width(WIDTH, ID_WIDTH);

    logic [NUM_REQ-1:0]                    grant;
    logic [ID_WIDTH-1:0]                   grantIdx;
    logic [ID_WIDTH-1:0]                   candIdx;
    logic                                  found;
    int                                    candSum;
    logic                                  canIssue;
    logic                                  issue;
    logic                                  pop;
    logic                                  inFlight;
    logic                                  fifoNotEmpty;
    logic                                  fifoWrEn;
    logic [ENTRY_WIDTH-1:0]                fifoWrData;
    logic [ENTRY_WIDTH-1:0]                fifoRdData;
    logic [ID_WIDTH-1:0]                   lastPtr_q, lastPtr_d;
    logic [CREDIT_WIDTH-1:0]               credits_q, credits_d;
    logic [WIDTH-1:0]                      fmaA_q, fmaA_d;
    logic [WIDTH-1:0]                      fmaB_q, fmaB_d;
    logic [WIDTH-1:0]                      fmaC_q, fmaC_d;
    logic [FMA_LATENCY:0][TAG_WIDTH-1:0]   tag;

    // Scan requesters starting just after the last winner, wrapping around.
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        candSum  = 0;
        candIdx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            candSum = int'(lastPtr_q) + k;
            if (candSum >= NUM_REQ) begin
                candSum = candSum - NUM_REQ;
            end
            candIdx = ID_WIDTH'(candSum);
            if (!found && i_req_valid[candIdx]) begin
                found           = 1'b1;
                grant[candIdx]  = 1'b1;
                grantIdx        = candIdx;
            end
        end
    end

    assign pop = fifoNotEmpty & i_rsp_ready & i_aclken;

    // A pop in this cycle frees a credit that may be spent immediately.
    // Reset gates readiness so no handshake is seen while the block is held.
    assign canIssue    = i_rst_n & i_aclken & ((credits_q != '0) | pop);
    assign o_req_ready = canIssue ? grant : '0;
    assign issue       = |(i_req_valid & o_req_ready);

    always_comb begin
        lastPtr_d = lastPtr_q;
        fmaA_d    = fmaA_q;
        fmaB_d    = fmaB_q;
        fmaC_d    = fmaC_q;
        credits_d = credits_q;
        if (issue) begin
            lastPtr_d = grantIdx;
            fmaA_d    = i_req_a[int'(grantIdx)*WIDTH +: WIDTH];
            fmaB_d    = i_req_b[int'(grantIdx)*WIDTH +: WIDTH];
            fmaC_d    = i_req_c[int'(grantIdx)*WIDTH +: WIDTH];
        end
        case ({issue, pop})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lastPtr_q <= ID_WIDTH'(NUM_REQ - 1);
            credits_q <= CREDIT_WIDTH'(FIFO_DEPTH);
            fmaA_q    <= '0;
            fmaB_q    <= '0;
            fmaC_q    <= '0;
        end else if (i_aclken) begin
            lastPtr_q <= lastPtr_d;
            credits_q <= credits_d;
            fmaA_q    <= fmaA_d;
            fmaB_q    <= fmaB_d;
            fmaC_q    <= fmaC_d;
        end
    end

    // The FMA samples operands in the issue cycle itself, so the granted
    // operands pass straight through and the hold registers cover idle cycles.
    assign o_fma_a     = fmaA_d;
    assign o_fma_b     = fmaB_d;
    assign o_fma_c     = fmaC_d;
    assign o_fma_valid = issue;

    // Tag delay line tracks which FMA output slots carry real work.
    assign tag[0] = {issue, grantIdx};

    for (genvar s = 0; s < FMA_LATENCY; s++) begin : g_delay
        ipsxe_floating_point_register_v1_0 #(
            .DATA_WIDTH (TAG_WIDTH)
        ) u_stage (
            .clk_i   (i_clk),
            .rst_n_i (i_rst_n),
            .en_i    (i_aclken),
            .d_i     (tag[s]),
            .q_o     (tag[s+1])
        );
    end

    always_comb begin
        inFlight = 1'b0;
        for (int s = 1; s <= FMA_LATENCY; s++) begin
            inFlight = inFlight | tag[s][TAG_WIDTH-1];
        end
    end

    // Credits guarantee room, so the tail write is never refused.
    assign fifoWrEn   = tag[FMA_LATENCY][TAG_WIDTH-1] & i_aclken;
    assign fifoWrData = {i_fma_result, i_fma_invalid_op, tag[FMA_LATENCY][ID_WIDTH-1:0]};

    ipsxe_floating_point_sync_fifo_v1_0 #(
        .DATA_WIDTH (ENTRY_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (i_clk),
        .rst_n_i     (i_rst_n),
        .wr_en_i     (fifoWrEn),
        .wr_data_i   (fifoWrData),
        .rd_en_i     (pop),
        .rd_data_o   (fifoRdData),
        .not_empty_o (fifoNotEmpty)
    );

    assign o_rsp_valid      = fifoNotEmpty;
    assign o_rsp_result     = fifoRdData[ENTRY_WIDTH-1 -: WIDTH];
    assign o_rsp_invalid_op = fifoRdData[ID_WIDTH];
    assign o_rsp_id         = fifoRdData[ID_WIDTH-1:0];
    assign o_busy           = inFlight | fifoNotEmpty;

endmodule

// File: tb/tb_ipsxe_floating_point_fma_arbiter_v1_0.sv
// ----------------------------------------------------------------------------
// tb_ipsxe_floating_point_fma_arbiter_v1_0
// Drives randomized and directed requester traffic into the arbiter, attaches
// a behavioural FMA pipeline, and scoreboards every response against a
// reference model of the round-robin / credit / latency rules.
// ----------------------------------------------------------------------------
module tb_ipsxe_floating_point_fma_arbiter_v1_0;

    localparam int NR    = 4;
    localparam int L     = 3;
    localparam int DEPTH = 4;
    localparam int W     = 32;

    typedef struct packed {
        logic [31:0] res;
        logic        inv;
        logic [1:0]  id;
    } rsp_t;

    logic            clk = 1'b0;
    logic            rstN = 1'b0;
    logic            aclken = 1'b0;
    logic            rspReady = 1'b0;
    logic [NR-1:0]   reqValid = '0;
    logic [31:0]     opA [NR];
    logic [31:0]     opB [NR];
    logic [31:0]     opC [NR];
    logic [NR*W-1:0] reqA, reqB, reqC;

    logic [NR-1:0]   reqReady;
    logic [W-1:0]    fmaA, fmaB, fmaC;
    logic            fmaValid;
    logic [W-1:0]    fmaResult;
    logic            fmaInvalid;
    logic            rspValid;
    logic [W-1:0]    rspResult;
    logic            rspInvalid;
    logic [1:0]      rspId;
    logic            busy;

    logic [32:0]     fmaPipe [L];

    int   vectors = 0;
    int   miscompares = 0;
    bit   modelOn = 1'b0;
    int   lastPtr, credits, ecnt, gIdx, cand;
    bit   rvExp, popExp;
    logic [NR-1:0] gExp;
    logic [32:0]   mres;
    rsp_t popped;
    rsp_t expQ [$];
    int   pendQ [$];

    always #5 clk = ~clk;

    ipsxe_floating_point_fma_arbiter_v1_0 #(
        .EXP_WIDTH   (8),
        .MAN_WIDTH   (23),
        .NUM_REQ     (NR),
        .FMA_LATENCY (L),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rstN),
        .i_aclken         (aclken),
        .i_req_valid      (reqValid),
        .o_req_ready      (reqReady),
        .i_req_a          (reqA),
        .i_req_b          (reqB),
        .i_req_c          (reqC),
        .o_fma_a          (fmaA),
        .o_fma_b          (fmaB),
        .o_fma_c          (fmaC),
        .o_fma_valid      (fmaValid),
        .i_fma_result     (fmaResult),
        .i_fma_invalid_op (fmaInvalid),
        .o_rsp_valid      (rspValid),
        .i_rsp_ready      (rspReady),
        .o_rsp_result     (rspResult),
        .o_rsp_invalid_op (rspInvalid),
        .o_rsp_id         (rspId),
        .o_busy           (busy)
    );

    // Pack the per-requester operand arrays onto the flat buses.
    always_comb begin
        reqA = '0;
        reqB = '0;
        reqC = '0;
        for (int i = 0; i < NR; i++) begin
            reqA[i*W +: W] = opA[i];
            reqB[i*W +: W] = opB[i];
            reqC[i*W +: W] = opC[i];
        end
    end

    // Behavioural FMA: {invalid, result}. inf*0 gives a quiet NaN with the
    // invalid flag; 1*2+3 gives 5.0; anything else gets a deterministic hash.
    function automatic logic [32:0] fmaModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
        if ((a[30:0] == 31'h7F800000 && b[30:0] == 31'h0) ||
            (b[30:0] == 31'h7F800000 && a[30:0] == 31'h0)) begin
            return {1'b1, 32'h7FC00000};
        end
        if (a == 32'h3F800000 && b == 32'h40000000 && c == 32'h40400000) begin
            return {1'b0, 32'h40A00000};
        end
        return {1'b0, (a ^ {b[15:0], b[31:16]}) + c};
    endfunction

    // FMA pipeline of depth L, advancing only on enabled cycles.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int k = 0; k < L; k++) fmaPipe[k] <= '0;
        end else if (aclken) begin
            fmaPipe[0] <= fmaModel(fmaA, fmaB, fmaC);
            for (int k = 1; k < L; k++) fmaPipe[k] <= fmaPipe[k-1];
        end
    end

    assign fmaResult  = fmaPipe[L-1][31:0];
    assign fmaInvalid = fmaPipe[L-1][32];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NR-1:0] v, input bit en, input bit rdy);
        @(posedge clk);
        #1;
        reqValid = v;
        aclken   = en;
        rspReady = rdy;
    endtask

    task automatic randomOps();
        for (int i = 0; i < NR; i++) begin
            opA[i] = $urandom;
            opB[i] = $urandom;
            opC[i] = $urandom;
        end
    endtask

    task automatic resetModel();
        lastPtr = NR - 1;
        credits = DEPTH;
        ecnt    = 0;
        pendQ.delete();
        expQ.delete();
    endtask

    task automatic checkResetOutputs(input string tagName);
        checkOutput({tagName, "_req_ready"}, reqReady, 0);
        checkOutput({tagName, "_fma_valid"}, fmaValid, 0);
        checkOutput({tagName, "_fma_a"}, fmaA, 0);
        checkOutput({tagName, "_rsp_valid"}, rspValid, 0);
        checkOutput({tagName, "_rsp_result"}, rspResult, 0);
        checkOutput({tagName, "_rsp_inv"}, rspInvalid, 0);
        checkOutput({tagName, "_rsp_id"}, rspId, 0);
        checkOutput({tagName, "_busy"}, busy, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (expQ.size() == 0 && pendQ.size() == 0) break;
            applyStimulus('0, 1'b1, 1'b1);
        end
        repeat (2) applyStimulus('0, 1'b1, 1'b1);
        checkOutput("drain_empty", expQ.size(), 0);
    endtask

    // Reference model: counts enabled cycles, tracks credits and outstanding
    // issues, predicts the grant and pushes the expected response.
    always @(negedge clk) begin
        if (rstN && modelOn) begin
            checkOutput("busy", busy, pendQ.size() > 0);
            rvExp = (pendQ.size() > 0) && (ecnt >= pendQ[0] + L + 1);
            checkOutput("rsp_valid", rspValid, rvExp);
            popExp = rvExp && rspReady && aclken;
            gExp = '0;
            gIdx = -1;
            if (aclken && (credits > 0 || popExp)) begin
                for (int k = 1; k <= NR; k++) begin
                    cand = (lastPtr + k) % NR;
                    if (gIdx < 0 && reqValid[cand]) gIdx = cand;
                end
            end
            if (gIdx >= 0) gExp[gIdx] = 1'b1;
            checkOutput("req_ready", reqReady, gExp);
            checkOutput("fma_valid", fmaValid, gIdx >= 0);
            if (gIdx >= 0) begin
                checkOutput("fma_a", fmaA, opA[gIdx]);
                checkOutput("fma_b", fmaB, opB[gIdx]);
                checkOutput("fma_c", fmaC, opC[gIdx]);
                mres = fmaModel(opA[gIdx], opB[gIdx], opC[gIdx]);
                expQ.push_back('{res: mres[31:0], inv: mres[32], id: 2'(gIdx)});
                pendQ.push_back(ecnt);
                lastPtr = gIdx;
                credits--;
            end
            if (popExp) begin
                void'(pendQ.pop_front());
                credits++;
            end
            if (aclken) ecnt++;
        end
    end

    // Monitor: every response the DUT hands over is checked against the queue.
    always @(negedge clk) begin
        #1;
        if (rstN && modelOn && rspValid && rspReady && aclken) begin
            checkOutput("rsp_expected", expQ.size() > 0, 1);
            if (expQ.size() > 0) begin
                popped = expQ.pop_front();
                checkOutput("rsp_result", rspResult, popped.res);
                checkOutput("rsp_inv", rspInvalid, popped.inv);
                checkOutput("rsp_id", rspId, popped.id);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            opA[i] = '0;
            opB[i] = '0;
            opC[i] = '0;
        end
        rstN     = 1'b0;
        aclken   = 1'b1;
        rspReady = 1'b1;
        reqValid = '1;
        resetModel();
        repeat (3) @(posedge clk);
        #2;
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rstN    = 1'b1;
        modelOn = 1'b1;

        $display("[TB] round-robin streaming");
        for (int i = 0; i < 16; i++) begin
            applyStimulus('1, 1'b1, 1'b1);
            randomOps();
        end
        drain();

        $display("[TB] single issue from requester 1");
        applyStimulus(4'b0010, 1'b1, 1'b1);
        opA[1] = 32'h3F800000;
        opB[1] = 32'h40000000;
        opC[1] = 32'h40400000;
        repeat (L + 4) applyStimulus('0, 1'b1, 1'b1);

        $display("[TB] invalid operation from requester 2");
        applyStimulus(4'b0100, 1'b1, 1'b1);
        opA[2] = 32'h7F800000;
        opB[2] = 32'h00000000;
        opC[2] = $urandom;
        repeat (L + 4) applyStimulus('0, 1'b1, 1'b1);

        $display("[TB] credit backpressure");
        for (int i = 0; i < 10; i++) begin
            applyStimulus('1, 1'b1, 1'b0);
            randomOps();
        end
        applyStimulus('1, 1'b1, 1'b1);
        randomOps();
        repeat (3) applyStimulus('1, 1'b1, 1'b0);
        repeat (6) applyStimulus('1, 1'b1, 1'b1);
        drain();

        $display("[TB] random clock-enable stalls");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(NR'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            randomOps();
        end
        drain();

        $display("[TB] reset with work in flight");
        repeat (3) begin
            applyStimulus(4'b0001, 1'b1, 1'b0);
            randomOps();
        end
        @(posedge clk);
        #1;
        rstN    = 1'b0;
        modelOn = 1'b0;
        #1;
        checkResetOutputs("midreset");
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        reqValid = '1;
        rspReady = 1'b1;
        aclken   = 1'b1;
        rstN     = 1'b1;
        modelOn  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus('1, 1'b1, 1'b1);
            randomOps();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
